// File: rtl/div_seq_ctrl_if.sv
// Request/response bundle between the execute stage and the sequential divider.
interface div_seq_ctrl_if #(
    parameter int unsigned BUS = 32
);
    logic           div_valid;
    logic           div_ready;
    logic           div_signed;
    logic [BUS-1:0] div_a;
    logic [BUS-1:0] div_b;
    logic           div_cancel;
    logic           busy;
    logic           res_valid;
    logic           res_ready;
    logic [BUS-1:0] res_quot;
    logic [BUS-1:0] res_rem;

    modport master (
        output div_valid, div_signed, div_a, div_b, div_cancel, res_ready,
        input  div_ready, busy, res_valid, res_quot, res_rem
    );

    modport slave (
        input  div_valid, div_signed, div_a, div_b, div_cancel, res_ready,
        output div_ready, busy, res_valid, res_quot, res_rem
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider for DIV/DIVU, one quotient bit per cycle.
// Optional DIV_ZERO_FAST_EN: divide-by-zero short-circuits from IDLE straight to DONE.
module div_seq_ctrl #(
    parameter int unsigned BUS   = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    div_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [BUS-1:0]   quo;
    logic [BUS-1:0]   rem;
    logic [BUS-1:0]   dvsr;
    logic [BUS-1:0]   a_raw;
    logic             sign_q;
    logic             sign_r;
    logic             b_zero;

    logic           a_neg;
    logic           b_neg;
    logic [BUS-1:0] a_abs;
    logic [BUS-1:0] b_abs;
    logic [BUS:0]   rem_sh;
    logic [BUS+1:0] sum;
    logic           borrow;
    logic           sum_unused;
    logic [BUS-1:0] q_fix;
    logic [BUS-1:0] r_fix;

    assign bus.div_ready = ~rst & (state == S_IDLE) & ~bus.div_cancel;

    // Operand magnitudes; abs only applies to signed requests
    assign a_neg = bus.div_signed & bus.div_a[BUS-1];
    assign b_neg = bus.div_signed & bus.div_b[BUS-1];
    assign a_abs = a_neg ? BUS'(-bus.div_a) : bus.div_a;
    assign b_abs = b_neg ? BUS'(-bus.div_b) : bus.div_b;

    // Trial subtract as add-with-inverted-divisor; carry out set means no borrow
    assign rem_sh     = {rem, quo[BUS-1]};
    assign sum        = {1'b0, rem_sh} + {1'b0, ~{1'b0, dvsr}} + (BUS+2)'(1);
    assign borrow     = ~sum[BUS+1];
    assign sum_unused = sum[BUS];

    always_comb begin
        q_fix = sign_q ? BUS'(-quo) : quo;
        r_fix = sign_r ? BUS'(-rem) : rem;
        if (b_zero) begin
            q_fix = '1;
            r_fix = a_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            quo           <= '0;
            rem           <= '0;
            dvsr          <= '0;
            a_raw         <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            b_zero        <= 1'b0;
            bus.busy      <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_quot  <= '0;
            bus.res_rem   <= '0;
        end else if (state != S_IDLE && bus.div_cancel) begin
            // Flush drops the operation but leaves the last result registers intact
            state         <= S_IDLE;
            bus.busy      <= 1'b0;
            bus.res_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.div_valid && bus.div_ready) begin
                        quo      <= a_abs;
                        dvsr     <= b_abs;
                        a_raw    <= bus.div_a;
                        sign_q   <= bus.div_signed & (bus.div_a[BUS-1] ^ bus.div_b[BUS-1]);
                        sign_r   <= a_neg;
                        b_zero   <= (bus.div_b == '0);
                        bus.busy <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                        if (bus.div_b == '0) begin
                            state         <= S_DONE;
                            bus.res_valid <= 1'b1;
                            bus.res_quot  <= '1;
                            bus.res_rem   <= bus.div_a;
                        end else begin
                            state <= S_PREP;
                        end
`else
                        state <= S_PREP;
`endif
                    end
                end
                S_PREP: begin
                    cnt   <= CNT_W'(BUS);
                    rem   <= '0;
                    state <= S_ITER;
                end
                S_ITER: begin
                    rem <= borrow ? rem_sh[BUS-1:0] : sum[BUS-1:0];
                    quo <= {quo[BUS-2:0], ~borrow};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    bus.res_quot  <= q_fix;
                    bus.res_rem   <= r_fix;
                    bus.res_valid <= 1'b1;
                    state         <= S_DONE;
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    bus.busy      <= 1'b0;
                    bus.res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: latency-level reference model plus directed literal checks.
module tb_div_seq_ctrl;

    localparam int unsigned LAT = 34;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
    localparam int unsigned ZLAT = 0;
`else
    localparam bit FAST = 1'b0;
    localparam int unsigned ZLAT = 34;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    div_seq_ctrl_if #(.BUS(32)) dif ();

    div_seq_ctrl #(.BUS(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of DIV/DIVU using wide signed arithmetic
    function automatic void model_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Model state: busy/valid flags, cycles left until result, visible and pending results
    logic        armed;
    logic        m_busy;
    logic        m_rv;
    int          m_wait;
    logic [31:0] m_q, m_r, p_q, p_r;

    initial begin
        armed = 1'b0; m_busy = 1'b0; m_rv = 1'b0; m_wait = 0;
        m_q = '0; m_r = '0; p_q = '0; p_r = '0;
    end

    always @(posedge clk) begin : model
        logic [31:0] tq;
        logic [31:0] tr;
        if (rst) begin
            armed  <= 1'b1;
            m_busy <= 1'b0;
            m_rv   <= 1'b0;
            m_wait <= 0;
            m_q    <= '0;
            m_r    <= '0;
        end else if (!m_busy) begin
            if (dif.div_valid && !dif.div_cancel) begin
                model_div(dif.div_signed, dif.div_a, dif.div_b, tq, tr);
                m_busy <= 1'b1;
                if (FAST && dif.div_b == 32'd0) begin
                    m_rv <= 1'b1;
                    m_q  <= tq;
                    m_r  <= tr;
                end else begin
                    p_q    <= tq;
                    p_r    <= tr;
                    m_wait <= LAT;
                end
            end
        end else if (dif.div_cancel) begin
            m_busy <= 1'b0;
            m_rv   <= 1'b0;
            m_wait <= 0;
        end else if (m_rv) begin
            if (dif.res_ready) begin
                m_busy <= 1'b0;
                m_rv   <= 1'b0;
            end
        end else begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_rv <= 1'b1;
                m_q  <= p_q;
                m_r  <= p_r;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("cyc_busy", 32'(dif.busy), 32'(m_busy));
            check("cyc_res_valid", 32'(dif.res_valid), 32'(m_rv));
            check("cyc_res_quot", dif.res_quot, m_q);
            check("cyc_res_rem", dif.res_rem, m_r);
            check("cyc_div_ready", 32'(dif.div_ready), 32'(!rst && !m_busy && !dif.div_cancel));
        end
    end

    task automatic start_op(input bit sg, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        dif.div_valid  = 1'b1;
        dif.div_signed = sg;
        dif.div_a      = a;
        dif.div_b      = b;
        @(negedge clk);
        check("accept_ready", 32'(dif.div_ready), 32'd1);
        @(posedge clk); #1;
        dif.div_valid = 1'b0;
        dif.div_a     = 32'hDEAD_BEEF;
        dif.div_b     = 32'h0BAD_F00D;
    endtask

    task automatic wait_result(input string name, input logic [31:0] q_exp, input logic [31:0] r_exp,
                               input int lat_exp);
        int lat;
        lat = 0;
        @(negedge clk);
        check({name, "_busy_first"}, 32'(dif.busy), 32'd1);
        while (!dif.res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(lat_exp));
        check({name, "_quot"}, dif.res_quot, q_exp);
        check({name, "_rem"}, dif.res_rem, r_exp);
    endtask

    task automatic release_result(input string name);
        @(posedge clk); #1;
        dif.res_ready = 1'b1;
        @(posedge clk); #1;
        dif.res_ready = 1'b0;
        @(negedge clk);
        check({name, "_valid_drop"}, 32'(dif.res_valid), 32'd0);
    endtask

    task automatic do_op(input string name, input bit sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q_exp, input logic [31:0] r_exp, input int lat_exp);
        start_op(sg, a, b);
        wait_result(name, q_exp, r_exp, lat_exp);
        release_result(name);
    endtask

    initial begin
        logic [31:0] mq;
        logic [31:0] mr;
        checks   = 0;
        failures = 0;
        rst            = 1'b1;
        dif.div_valid  = 1'b0;
        dif.div_signed = 1'b0;
        dif.div_a      = '0;
        dif.div_b      = '0;
        dif.div_cancel = 1'b0;
        dif.res_ready  = 1'b0;

        // Pin the reference model against hand-derived results
        model_div(1'b1, 32'hFFFF_FFF9, 32'd2, mq, mr);
        check("model_neg7_div2", {mq ^ 32'hFFFF_FFFD} | {mr ^ 32'hFFFF_FFFF}, 32'd0);
        model_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mq, mr);
        check("model_ovf", {mq ^ 32'h8000_0000} | mr, 32'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(dif.busy), 32'd0);
        check("rst_res_valid", 32'(dif.res_valid), 32'd0);
        check("rst_quot", dif.res_quot, 32'd0);
        check("rst_rem", dif.res_rem, 32'd0);
        check("rst_ready", 32'(dif.div_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(dif.div_ready), 32'd1);

        do_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34);
        do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
        do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34);
        do_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34);
        do_op("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34);
        do_op("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, ZLAT);
        do_op("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, ZLAT);

        // Hold result with res_ready low for 5 cycles
        start_op(1'b0, 32'd1000, 32'd10);
        wait_result("hold", 32'd100, 32'd0, 34);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(dif.res_valid), 32'd1);
            check("hold_quot", dif.res_quot, 32'd100);
            check("hold_rem", dif.res_rem, 32'd0);
            check("hold_ready", 32'(dif.div_ready), 32'd0);
        end
        release_result("hold");

        // Cancel on the 10th ITER cycle, then a fresh operation
        start_op(1'b0, 32'd77, 32'd5);
        repeat (10) @(posedge clk);
        #1 dif.div_cancel = 1'b1;
        @(posedge clk); #1;
        dif.div_cancel = 1'b0;
        @(negedge clk);
        check("cancel_valid", 32'(dif.res_valid), 32'd0);
        check("cancel_ready", 32'(dif.div_ready), 32'd1);
        check("cancel_quot_kept", dif.res_quot, 32'd100);
        repeat (40) begin
            @(negedge clk);
            check("cancel_no_result", 32'(dif.res_valid), 32'd0);
        end
        do_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34);

        // Cancel while idle blocks the accept
        @(posedge clk); #1;
        dif.div_valid  = 1'b1;
        dif.div_cancel = 1'b1;
        @(negedge clk);
        check("idle_cancel_ready", 32'(dif.div_ready), 32'd0);
        @(posedge clk); #1;
        dif.div_valid  = 1'b0;
        dif.div_cancel = 1'b0;
        @(negedge clk);
        check("idle_cancel_busy", 32'(dif.busy), 32'd0);

        // Cancel and res_ready together in DONE: result dropped, registers kept
        start_op(1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_result("cancel_done", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 34);
        @(posedge clk); #1;
        dif.div_cancel = 1'b1;
        dif.res_ready  = 1'b1;
        @(posedge clk); #1;
        dif.div_cancel = 1'b0;
        dif.res_ready  = 1'b0;
        @(negedge clk);
        check("cancel_done_valid", 32'(dif.res_valid), 32'd0);
        check("cancel_done_quot", dif.res_quot, 32'hFFFF_FFF2);

        // Reset pulse mid-iteration
        start_op(1'b0, 32'd100, 32'd7);
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(dif.busy), 32'd0);
        check("midrst_valid", 32'(dif.res_valid), 32'd0);
        check("midrst_quot", dif.res_quot, 32'd0);
        check("midrst_rem", dif.res_rem, 32'd0);
        check("midrst_ready", 32'(dif.div_ready), 32'd1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
